// File: rtl/flash_pkg.sv
// Shared constants and state encoding for the SPI flash reader.
package flash_pkg;

  localparam logic [7:0] CMD_READ       = 8'h03;
  localparam logic [7:0] CMD_RELEASE_PD = 8'hAB;

  typedef enum logic [2:0] {
    S_WAKE,
    S_WAKE_WAIT,
    S_IDLE,
    S_CMD,
    S_DATA,
    S_HOLD,
    S_DESEL
  } state_t;

endpackage

// File: rtl/spi_shifter.sv
// Mode-0 SPI engine: SCK divider plus N-bit MSB-first shift.
module spi_shifter #(
  parameter int DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  nbits,
  input  logic [31:0] tx,
  input  logic        miso,
  output logic        sck,
  output logic        mosi,
  output logic        busy,
  output logic        last,
  output logic [7:0]  rx
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(DIV - 1);

  logic [TW-1:0] tick;
  logic [5:0]    cnt;
  logic [31:0]   sh;
  logic          half_end;

  assign half_end = busy && (tick == TMAX);
  // last is the cycle whose edge drops SCK after the final bit
  assign last = half_end && sck && (cnt == 6'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      sck  <= 1'b0;
      mosi <= 1'b0;
      tick <= '0;
      cnt  <= '0;
      sh   <= '0;
      rx   <= '0;
    end else if (start) begin
      busy <= 1'b1;
      sck  <= 1'b0;
      tick <= '0;
      cnt  <= nbits;
      mosi <= tx[31];
      sh   <= {tx[30:0], 1'b0};
    end else if (busy) begin
      if (half_end) begin
        tick <= '0;
        sck  <= ~sck;
        if (!sck) begin
          rx <= {rx[6:0], miso};
        end else begin
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            busy <= 1'b0;
            mosi <= 1'b0;
          end else begin
            mosi <= sh[31];
            sh   <= {sh[30:0], 1'b0};
          end
        end
      end else begin
        tick <= tick + TW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// Byte reader for SPI NOR flash: READ (0x03) with CS held
// open so sequential addresses stream without a new command.
module spi_flash_reader
  import flash_pkg::*;
#(
  parameter int          ADDRESS_BITS = 14,
  parameter logic [23:0] FLASH_BASE   = 24'h100000,
  parameter int          SCK_DIV      = 2,
  parameter int          HOLD_CYCLES  = 64,
  parameter int          WAKE_CYCLES  = 256
) (
  input  logic                    clock_in,
  input  logic                    resetn_in,
  input  logic [ADDRESS_BITS-1:0] address_in,
  input  logic                    read_in,
  output logic                    ready_out,
  output logic [7:0]              data_out,
  output logic                    valid_out,
  output logic                    spi_csn_out,
  output logic                    spi_sck_out,
  output logic                    spi_mosi_out,
  input  logic                    spi_miso_in
);

  localparam int C1   = (WAKE_CYCLES > HOLD_CYCLES)
                        ? WAKE_CYCLES : HOLD_CYCLES;
  localparam int CMAX = (C1 > 2 * SCK_DIV) ? C1 : 2 * SCK_DIV;
  localparam int CW   = $clog2(CMAX + 1);

  state_t        state, state_n;
  logic          csn_n;
  logic [23:0]   addr, addr_n, req_addr;
  logic [CW-1:0] cnt, cnt_n;
  logic          start, busy, last, load, accept;
  logic [31:0]   tx;
  logic [5:0]    nbits;
  logic [7:0]    rx;

  assign req_addr  = FLASH_BASE + 24'(address_in);
  assign ready_out = ((state == S_IDLE) || (state == S_HOLD))
                     && !valid_out;
  assign accept    = read_in && ready_out;

  spi_shifter #(.DIV(SCK_DIV)) u_shifter (
    .clk   (clock_in),
    .rst_n (resetn_in),
    .start (start),
    .nbits (nbits),
    .tx    (tx),
    .miso  (spi_miso_in),
    .sck   (spi_sck_out),
    .mosi  (spi_mosi_out),
    .busy  (busy),
    .last  (last),
    .rx    (rx)
  );

  always_ff @(posedge clock_in or negedge resetn_in) begin
    if (!resetn_in) begin
      state       <= S_WAKE;
      spi_csn_out <= 1'b1;
      addr        <= '0;
      cnt         <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
    end else begin
      state       <= state_n;
      spi_csn_out <= csn_n;
      addr        <= addr_n;
      cnt         <= cnt_n;
      valid_out   <= load;
      if (load) data_out <= rx;
    end
  end

  always_comb begin
    state_n = state;
    csn_n   = spi_csn_out;
    addr_n  = addr;
    cnt_n   = cnt;
    start   = 1'b0;
    tx      = '0;
    nbits   = 6'd8;
    load    = 1'b0;
    unique case (state)
      S_WAKE: begin
        if (!busy) begin
          start = 1'b1;
          tx    = {CMD_RELEASE_PD, 24'h0};
          csn_n = 1'b0;
        end else if (last) begin
          csn_n   = 1'b1;
          cnt_n   = '0;
          state_n = S_WAKE_WAIT;
        end
      end
      S_WAKE_WAIT: begin
        if (cnt == CW'(WAKE_CYCLES - 1)) state_n = S_IDLE;
        else cnt_n = cnt + CW'(1);
      end
      S_IDLE: begin
        if (accept) begin
          addr_n  = req_addr;
          csn_n   = 1'b0;
          start   = 1'b1;
          tx      = {CMD_READ, req_addr};
          nbits   = 6'd32;
          state_n = S_CMD;
        end
      end
      S_CMD: begin
        // chain straight into the data byte, no idle SCK gap
        if (last) begin
          start   = 1'b1;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (last) begin
          load    = 1'b1;
          cnt_n   = '0;
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (accept) begin
          addr_n = req_addr;
          cnt_n  = '0;
          if (req_addr == addr + 24'd1) begin
            start   = 1'b1;
            state_n = S_DATA;
          end else begin
            csn_n   = 1'b1;
            state_n = S_DESEL;
          end
        end else if (cnt == CW'(HOLD_CYCLES - 1)) begin
          csn_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DESEL: begin
        if (cnt == CW'(2 * SCK_DIV - 1)) begin
          csn_n   = 1'b0;
          start   = 1'b1;
          tx      = {CMD_READ, addr};
          nbits   = 6'd32;
          state_n = S_CMD;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = S_WAKE;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural
// SPI NOR flash model (byte at a = a[7:0] ^ 0x5F).
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [13:0] address = '0;
  logic        read = 1'b0;
  logic        ready, valid, csn, sck, mosi;
  logic        miso = 1'b0;
  logic [7:0]  data;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;

  spi_flash_reader dut (
    .clock_in     (clk),
    .resetn_in    (resetn),
    .address_in   (address),
    .read_in      (read),
    .ready_out    (ready),
    .data_out     (data),
    .valid_out    (valid),
    .spi_csn_out  (csn),
    .spi_sck_out  (sck),
    .spi_mosi_out (mosi),
    .spi_miso_in  (miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  int vcount = 0;
  always @(posedge clk) if (valid === 1'b1) vcount++;

  // flash model
  int          pulses = 0;
  int          mbits = 0;
  int          cs_rises = 0;
  int          rise_cyc = 0;
  int          fall_cyc = 0;
  int          last_bits = 0;
  int          k;
  logic [31:0] msh = '0;
  logic [7:0]  last_low8 = '0;
  logic [7:0]  mcmd = '0;
  logic [23:0] faddr = '0;
  logic [7:0]  mbyte = '0;

  function automatic logic [7:0] fmem(input logic [23:0] a);
    return a[7:0] ^ 8'h5F;
  endfunction

  always @(negedge csn) begin
    mbits = 0;
    fall_cyc = cyc;
  end

  always @(posedge csn) begin
    rise_cyc = cyc;
    cs_rises++;
    last_bits = mbits;
    last_low8 = msh[7:0];
  end

  always @(posedge sck) begin
    pulses++;
    if (csn === 1'b0) begin
      msh = {msh[30:0], mosi};
      mbits++;
      if (mbits == 32) begin
        mcmd  = msh[31:24];
        faddr = msh[23:0];
      end
    end
  end

  always @(negedge sck) begin
    if (csn === 1'b0 && mbits >= 32) begin
      k = mbits - 32;
      if (k % 8 == 0) mbyte = fmem(faddr + 24'(k / 8));
      miso = mbyte[7 - (k % 8)];
    end
  end

  typedef struct {
    logic [13:0] addr;
    int          gap;
    int          lat;
    logic [7:0]  data;
    int          pulses;
    int          rises;
    int          desel;
    logic        csn_before;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_read(input vec_t v);
    int          p0, r0, lat;
    bit          ok;
    logic [23:0] fa;
    repeat (v.gap) @(negedge clk);
    chk("csn_before", 32'(csn), 32'(v.csn_before));
    wait_ready(50, ok);
    chk("ready_seen", 32'(ok), 1);
    p0 = pulses;
    r0 = cs_rises;
    address = v.addr;
    read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    read = 1'b0;
    lat = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, v.lat);
    chk("data", 32'(data), 32'(v.data));
    chk("ready_with_valid", 32'(ready), 0);
    chk("sck_pulses", pulses - p0, v.pulses);
    chk("cs_rises", cs_rises - r0, v.rises);
    if (v.pulses == 40) begin
      fa = 24'h100000 + 24'(v.addr);
      chk("cmd", 32'(mcmd), 32'h03);
      chk("flash_addr", 32'(faddr), 32'(fa));
    end
    if (v.desel > 0)
      chk("desel_time", 32'((fall_cyc - rise_cyc) >= v.desel), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int p0, v0;
    vec_t fin;

    vecs[0] = '{14'h0005, 0,  160, 8'h5A, 40, 0, 0, 1'b1};
    vecs[1] = '{14'h0006, 0,  32,  8'h59, 8,  0, 0, 1'b0};
    vecs[2] = '{14'h0100, 0,  164, 8'h5F, 40, 1, 4, 1'b0};
    vecs[3] = '{14'h0006, 70, 160, 8'h59, 40, 0, 0, 1'b1};
    vecs[4] = '{14'h0007, 0,  32,  8'h58, 8,  0, 0, 1'b0};
    vecs[5] = '{14'h3FFF, 0,  164, 8'hA0, 40, 1, 4, 1'b0};

    #2 resetn = 1'b0;
    #1;
    chk("rst_csn", 32'(csn), 1);
    chk("rst_sck", 32'(sck), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_ready", 32'(ready), 0);
    repeat (3) @(negedge clk);
    p0 = pulses;
    resetn = 1'b1;

    wait_ready(2000, ok);
    chk("wake_ready", 32'(ok), 1);
    chk("wake_pulses", pulses - p0, 8);
    chk("wake_bits", last_bits, 8);
    chk("wake_byte", 32'(last_low8), 32'hAB);
    chk("wake_csn", 32'(csn), 1);
    chk("wake_wait", cyc - rise_cyc, 256);

    for (int i = 0; i < 6; i++) do_read(vecs[i]);

    // reset in the middle of the command phase
    repeat (70) @(negedge clk);
    wait_ready(50, ok);
    chk("rst_case_ready", 32'(ok), 1);
    address = 14'h0005;
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (mbits >= 20) break;
      @(negedge clk);
    end
    chk("cmd_bit20", 32'(mbits), 20);
    v0 = vcount;
    resetn = 1'b0;
    read = 1'b1;
    #1;
    chk("async_csn", 32'(csn), 1);
    chk("async_sck", 32'(sck), 0);
    chk("async_ready", 32'(ready), 0);
    @(negedge clk);
    @(negedge clk);
    p0 = pulses;
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    read = 1'b0;
    wait_ready(2000, ok);
    chk("rewake_ready", 32'(ok), 1);
    chk("rewake_pulses", pulses - p0, 8);
    chk("rewake_byte", 32'(last_low8), 32'hAB);
    chk("no_valid_dropped", vcount - v0, 0);
    p0 = pulses;
    repeat (20) @(negedge clk);
    chk("no_queued_csn", 32'(csn), 1);
    chk("no_queued_sck", pulses - p0, 0);

    fin = '{14'h0010, 0, 160, 8'h4F, 40, 0, 0, 1'b1};
    do_read(fin);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
